// File: rtl/barrett_mod_multi_pkg.sv
// Shared helpers for the multi-modulus Barrett reduction pipeline.
// Struct widths depend on instance parameters, so the structs themselves live in the top.
package barrett_mod_multi_pkg;

    // Width of the Barrett constant mu = floor(2^(2k)/p) for a k-bit modulus.
    function automatic int mu_width(input int k);
        return k + 2;
    endfunction

    // Table select width, at least one bit even for a single-entry table.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/barrett_mod_multi_pipe_mult.sv
// LAT-stage registered multiplier with hold enable; emits the product shifted right by SHIFT.
// Only the kept upper bits are registered, which keeps the pipeline registers narrow.
module pipe_mult #(
    parameter int A_BITS = 8,
    parameter int B_BITS = 8,
    parameter int LAT    = 1,
    parameter int SHIFT  = 0,
    localparam int P_BITS = A_BITS + B_BITS,
    localparam int O_BITS = P_BITS - SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [A_BITS-1:0] a,
    input  logic [B_BITS-1:0] b,
    output logic [O_BITS-1:0] y
);

    logic [P_BITS-1:0] prod;
    logic [O_BITS-1:0] stg [LAT];

    assign prod = P_BITS'(a) * P_BITS'(b);

    generate
        if (SHIFT > 0) begin : g_drop
            logic unused_lo;
            assign unused_lo = ^prod[SHIFT-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stg[i] <= '0;
        end else if (en) begin
            stg[0] <= prod[P_BITS-1:SHIFT];
            for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
        end
    end

    assign y = stg[LAT-1];

endmodule

// File: rtl/barrett_mod_multi.sv
// Barrett reduction of a 2k-bit operand modulo one of NUM_MOD runtime-programmable moduli.
// Optional sticky error checking is enabled with `define BARRETT_MOD_MULTI_ERR_CHK_EN.
module barrett_mod_multi
    import barrett_mod_multi_pkg::*;
#(
    parameter int DAT_BITS = 256,
    parameter int CTL_BITS = 8,
    parameter int NUM_MOD  = 4,
    parameter int MUL_LAT  = 3,
    parameter int SEL_BITS = sel_width(NUM_MOD)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cfg_wr,
    input  logic [SEL_BITS-1:0]   i_cfg_idx,
    input  logic [DAT_BITS-1:0]   i_cfg_p,
    input  logic [DAT_BITS+1:0]   i_cfg_u,
    input  logic [2*DAT_BITS-1:0] i_dat,
    input  logic [SEL_BITS-1:0]   i_sel,
    input  logic [CTL_BITS-1:0]   i_ctl,
    input  logic                  i_val,
    output logic                  o_rdy,
    output logic [DAT_BITS-1:0]   o_dat,
    output logic [CTL_BITS-1:0]   o_ctl,
    output logic                  o_val,
    input  logic                  i_rdy,
    output logic                  o_err
);

    localparam int K      = DAT_BITS;
    localparam int U_BITS = mu_width(DAT_BITS);
    localparam int TBL    = 2 ** SEL_BITS;
    localparam int DL     = 2 * MUL_LAT;

    typedef struct packed {
        logic [K-1:0]      p;
        logic [U_BITS-1:0] mu;
        logic              vld;
    } mod_entry_t;

    typedef struct packed {
        logic [2*K-1:0]    x;
        logic [K-1:0]      p;
        logic [U_BITS-1:0] mu;
        logic [CTL_BITS-1:0] ctl;
        logic              cfg;
        logic              vld;
    } pay_t;

    // Sideband beside the multipliers; only the low k+2 bits of x matter after M1.
    typedef struct packed {
        logic [K+1:0]        x;
        logic [K-1:0]        p;
        logic [CTL_BITS-1:0] ctl;
        logic                cfg;
        logic                vld;
    } side_t;

    logic stall, en, rdy, acc;
    logic wr_ok;
    logic [TBL-1:0] wr_hit;
    logic [TBL-1:0] tbl_vld;
    logic [K-1:0]      tbl_p  [TBL];
    logic [U_BITS-1:0] tbl_mu [TBL];
    mod_entry_t sel_ent;
    pay_t  s0;
    side_t dl [DL];
    side_t s1;
    logic [K+1:0]   q3;
    logic [2*K+1:0] t;
    logic [K+1:0]   r2, r3;
    logic [K-1:0]   dat_reg;
    logic [CTL_BITS-1:0] ctl_reg;
    logic           val_reg;
    logic           unused_bits;

    assign stall = val_reg & ~i_rdy;
    assign rdy   = ~stall;
    assign en    = rdy;
    assign acc   = i_val & rdy;
    assign o_rdy = rdy;

    // Modulus table: a write with a clear MSB is an invalid modulus and is dropped.
    assign wr_ok = i_cfg_wr & i_cfg_p[K-1];

    generate
        for (genvar gi = 0; gi < TBL; gi++) begin : g_hit
            if (gi < NUM_MOD) begin : g_live
                assign wr_hit[gi] = wr_ok && (i_cfg_idx == SEL_BITS'(gi));
            end else begin : g_dead
                assign wr_hit[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) tbl_vld <= '0;
        else       tbl_vld <= tbl_vld | wr_hit;
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            tbl_p[i_cfg_idx]  <= i_cfg_p;
            tbl_mu[i_cfg_idx] <= i_cfg_u;
        end
    end

    // Snapshot reads the pre-write contents, so a same-cycle write never leaks in.
    assign sel_ent = '{p: tbl_p[i_sel], mu: tbl_mu[i_sel], vld: tbl_vld[i_sel]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s0 <= '0;
        end else if (en) begin
            s0 <= '{x: i_dat, p: sel_ent.p, mu: sel_ent.mu, ctl: i_ctl,
                    cfg: sel_ent.vld, vld: acc};
        end
    end

    // M1: q3 = ((x >> (k-1)) * mu) >> (k+1)
    pipe_mult #(.A_BITS(K + 1), .B_BITS(U_BITS), .LAT(MUL_LAT), .SHIFT(K + 1)) u_m1 (
        .clk (i_clk),
        .rst (i_rst),
        .en  (en),
        .a   (s0.x[2*K-1:K-1]),
        .b   (s0.mu),
        .y   (q3)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DL; i++) dl[i] <= '0;
        end else if (en) begin
            dl[0] <= '{x: s0.x[K+1:0], p: s0.p, ctl: s0.ctl, cfg: s0.cfg, vld: s0.vld};
            for (int i = 1; i < DL; i++) dl[i] <= dl[i-1];
        end
    end

    // M2: t = q3 * p, aligned with the sideband leaving the first half of the delay line.
    pipe_mult #(.A_BITS(K + 2), .B_BITS(K), .LAT(MUL_LAT), .SHIFT(0)) u_m2 (
        .clk (i_clk),
        .rst (i_rst),
        .en  (en),
        .a   (q3),
        .b   (dl[MUL_LAT-1].p),
        .y   (t)
    );

    // S1: difference taken modulo 2^(k+2); wrap is intended since the true value is < 3p.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1 <= '0;
        end else if (en) begin
            s1     <= dl[DL-1];
            s1.x   <= dl[DL-1].x - t[K+1:0];
        end
    end

    always_comb begin
        r2 = (s1.x >= {2'b00, s1.p}) ? s1.x - {2'b00, s1.p} : s1.x;
        r3 = (r2 >= {2'b00, s1.p}) ? r2 - {2'b00, s1.p} : r2;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dat_reg <= '0;
            ctl_reg <= '0;
            val_reg <= 1'b0;
        end else if (en) begin
            dat_reg <= s1.cfg ? r3[K-1:0] : '0;
            ctl_reg <= s1.ctl;
            val_reg <= s1.vld;
        end
    end

    assign o_dat = dat_reg;
    assign o_ctl = ctl_reg;
    assign o_val = val_reg;

    assign unused_bits = ^{t[2*K+1:K+2], r3[K+1:K]};

`ifdef BARRETT_MOD_MULTI_ERR_CHK_EN
    logic err_reg;
    logic over;

    // A residue still >= p after two subtracts means x was outside [0, p^2).
    assign over = r3 >= {2'b00, s1.p};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_reg <= 1'b0;
        end else if ((acc && !sel_ent.vld) || (i_cfg_wr && !i_cfg_p[K-1]) ||
                     (en && s1.vld && s1.cfg && over)) begin
            err_reg <= 1'b1;
        end
    end

    assign o_err = err_reg;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_barrett_mod_multi.sv
// Self-checking bench for barrett_mod_multi: directed cases plus randomized traffic
// scored against a plain x % p model with per-item latency and sticky-error tracking.
module tb_barrett_mod_multi;

    localparam int K    = 8;
    localparam int CTL  = 8;
    localparam int NMOD = 4;
    localparam int ML   = 1;
    localparam int SEL  = 2;
    localparam int L    = 2 * ML + 3;

`ifdef BARRETT_MOD_MULTI_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_wr;
    logic [SEL-1:0] cfg_idx;
    logic [K-1:0]   cfg_p;
    logic [K+1:0]   cfg_u;
    logic [2*K-1:0] dat_in;
    logic [SEL-1:0] sel;
    logic [CTL-1:0] ctl_in;
    logic           val_in;
    logic           rdy_out;
    logic [K-1:0]   dat_out;
    logic [CTL-1:0] ctl_out;
    logic           val_out;
    logic           rdy_in;
    logic           err;

    always #5 clk = ~clk;

    barrett_mod_multi #(
        .DAT_BITS (K),
        .CTL_BITS (CTL),
        .NUM_MOD  (NMOD),
        .MUL_LAT  (ML),
        .SEL_BITS (SEL)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_cfg_wr  (cfg_wr),
        .i_cfg_idx (cfg_idx),
        .i_cfg_p   (cfg_p),
        .i_cfg_u   (cfg_u),
        .i_dat     (dat_in),
        .i_sel     (sel),
        .i_ctl     (ctl_in),
        .i_val     (val_in),
        .o_rdy     (rdy_out),
        .o_dat     (dat_out),
        .o_ctl     (ctl_out),
        .o_val     (val_out),
        .i_rdy     (rdy_in),
        .o_err     (err)
    );

    typedef struct {
        int dat;
        int ctl;
        int acc_cyc;
        int stall_at;
    } exp_t;

    exp_t sb[$];
    int   m_p   [NMOD];
    bit   m_vld [NMOD];
    bit   err_m;
    bit   head_seen;
    bit   rdy_rand;
    int   cyc, stalls;
    int   n_chk, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Mid-cycle monitor: everything seen here takes effect at the next rising edge.
    always @(negedge clk) begin
        bit ev;
        int s;
        cyc++;
        ev = 1'b0;
        if (!rst) begin
            check("o_err", err, err_m);
            check("o_rdy", rdy_out, !(val_out && !rdy_in));
            if (val_out) begin
                if (sb.size() == 0) begin
                    check("spurious_o_val", val_out, 0);
                end else begin
                    if (!head_seen) begin
                        check("latency", cyc - sb[0].acc_cyc, L + stalls - sb[0].stall_at);
                        head_seen = 1'b1;
                    end
                    check("o_dat", dat_out, sb[0].dat);
                    check("o_ctl", ctl_out, sb[0].ctl);
                    if (rdy_in) begin
                        $display("result dat=%0d ctl=0x%02h cycle=%0d", dat_out, ctl_out, cyc);
                        void'(sb.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            if (val_in && rdy_out) begin
                s = int'(sel);
                if (!m_vld[s]) ev = 1'b1;
                sb.push_back('{m_vld[s] ? int'(dat_in) % m_p[s] : 0, int'(ctl_in), cyc, stalls});
            end
            if (val_out && !rdy_in) stalls++;
            if (cfg_wr) begin
                if (cfg_p[K-1]) begin
                    m_p[int'(cfg_idx)]   = int'(cfg_p);
                    m_vld[int'(cfg_idx)] = 1'b1;
                end else begin
                    ev = 1'b1;
                end
            end
            if (ERR_EN && ev) err_m = 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) rdy_in = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cfg(input int idx, input int p, input int mu);
        cfg_idx = SEL'(idx);
        cfg_p   = K'(p);
        cfg_u   = (K+2)'(mu);
        cfg_wr  = 1'b1;
        @(posedge clk);
        #1;
        cfg_wr  = 1'b0;
    endtask

    task automatic send(input int x, input int s, input int c);
        int n;
        n = 0;
        dat_in = (2*K)'(x);
        sel    = SEL'(s);
        ctl_in = CTL'(c);
        val_in = 1'b1;
        @(negedge clk);
        while (!rdy_out) begin
            n++;
            if (n > 200) begin
                timeout("send");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        val_in = 1'b0;
    endtask

    task automatic wait_out(input string name, input int exp_dat, input int exp_ctl, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!val_out && n < 50);
        if (!val_out) begin
            timeout(name);
        end else begin
            check({name, "_dat"}, dat_out, exp_dat);
            check({name, "_ctl"}, ctl_out, exp_ctl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < NMOD; i++) m_vld[i] = 1'b0;
        err_m     = 1'b0;
        head_seen = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        int n, x, s, p, r;
        rst = 1'b1; cfg_wr = 1'b0; cfg_idx = '0; cfg_p = '0; cfg_u = '0;
        dat_in = '0; sel = '0; ctl_in = '0; val_in = 1'b0; rdy_in = 1'b1; rdy_rand = 1'b0;
        n_chk = 0; n_fail = 0; cyc = 0; stalls = 0;
        model_reset();
        #1;
        check("rst_o_val", val_out, 0);
        check("rst_o_err", err, 0);
        check("rst_o_dat", dat_out, 0);
        check("rst_o_ctl", ctl_out, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_rdy", rdy_out, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single item, exact latency.
        cfg(0, 251, 261);
        send(62500, 0, 'h5A);
        wait_out("t1", 1, 'h5A, n);
        check("t1_latency", n, 5);

        // Back-to-back over two moduli; 63000 is the largest legal x for p=251.
        cfg(1, 241, 271);
        send(57600, 1, 'h01);
        send(0, 0, 'h02);
        send(63000, 0, 'h03);
        wait_out("t2a", 1, 'h01, n);
        wait_out("t2b", 0, 'h02, n);
        check("t2_rate_b", n, 1);
        wait_out("t2c", 250, 'h03, n);
        check("t2_rate_c", n, 1);

        // Fill the pipeline against a blocked sink, hold, then release.
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) send(1000 + 9000 * i, i % 2, 'h10 + i);
        dat_in = 16'd50000; sel = 2'd0; ctl_in = 8'h20; val_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_o_rdy", rdy_out, 0);
            check("stall_o_val", val_out, 1);
            check("stall_o_dat", dat_out, sb[0].dat);
            check("stall_o_ctl", ctl_out, sb[0].ctl);
            @(posedge clk);
            #1;
        end
        rdy_in = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        val_in = 1'b0;
        drain("stall_drain");

        // Overwrite entry 0 in the same cycle an input selects it.
        cfg_idx = 2'd0; cfg_p = 8'd241; cfg_u = 10'd271; cfg_wr = 1'b1;
        send(62500, 0, 'h44);
        cfg_wr = 1'b0;
        wait_out("t4_old", 1, 'h44, n);
        send(57600, 0, 'h45);
        wait_out("t4_new", 1, 'h45, n);

        // Unconfigured select flows through with zero data.
        send(100, 2, 'h66);
        wait_out("t5", 0, 'h66, n);
        check("t5_o_err", err, ERR_EN);

        // Invalid modulus (MSB clear) leaves the entry untouched.
        cfg(0, 251, 261);
        cfg(0, 100, 7);
        send(62500, 0, 'h77);
        wait_out("t6", 1, 'h77, n);
        check("t6_o_err", err, ERR_EN);

        // Randomized traffic with sink backpressure and interleaved table writes.
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                p = $urandom_range(100, 255);
                cfg($urandom_range(0, 3), p, 65536 / p);
            end else if (r == 1) begin
                @(posedge clk);
                #1;
            end else begin
                s = $urandom_range(0, 3);
                if (!m_vld[s]) begin
                    x = $urandom_range(0, 65535);
                end else begin
                    p = m_p[s];
                    case ($urandom_range(0, 4))
                        0:       x = p * p - 1;
                        1:       x = 0;
                        2:       x = p;
                        default: x = $urandom_range(0, p * p - 1);
                    endcase
                end
                send(x, s, $urandom_range(0, 255));
            end
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        rdy_in = 1'b1;
        drain("rand_drain");

        // Reset in the middle of a stream.
        cfg(0, 251, 261);
        send(62500, 0, 'h91);
        send(1234, 0, 'h92);
        send(4321, 0, 'h93);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_o_val", val_out, 0);
        check("mid_rst_o_err", err, 0);
        check("mid_rst_o_rdy", rdy_out, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        send(62500, 0, 'h99);
        wait_out("post_rst", 0, 'h99, n);
        check("post_rst_o_err", err, ERR_EN);
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
